// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with mid-bit sampling and a one-deep valid/ready holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx_core #(
    parameter int CLK_FREQ_HZ = 72_000_000,
    parameter int BAUD_RATE   = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_error,
    output logic       overrun
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);

    if (CLKS_PER_BIT < 8) begin : g_bad_cfg
        $error("uart_rx_core: CLKS_PER_BIT must be >= 8");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             rx_m;
    logic             rx_s;
    logic             samp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // rx_m is next cycle's rx_s, so the vote spans target-1..target+1
    // while the decision still lands on the target count.
    logic rx_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_p <= 1'b1;
        end else begin
            rx_p <= rx_s;
        end
    end

    assign samp = (rx_m & rx_s) | (rx_m & rx_p) | (rx_s & rx_p);
`else
    assign samp = rx_s;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            data_out    <= '0;
            valid       <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            overrun     <= 1'b0;
            if (valid && ready) begin
                valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF_END) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= samp ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_END) begin
                        cnt            <= '0;
                        shift[bit_idx] <= samp;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_END) begin
                        cnt <= '0;
                        if (samp) begin
                            state <= IDLE;
                            // a consumer taking the old byte frees the slot now
                            if (!valid || ready) begin
                                data_out <= shift;
                                valid    <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_error <= 1'b1;
                            state       <= BRK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BRK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core at 16 clocks per bit.
module tb_uart_rx_core;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       frame_error;
    logic       overrun;

    uart_rx_core #(
        .CLK_FREQ_HZ(1_843_200),
        .BAUD_RATE  (115_200)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data_out   (data_out),
        .valid      (valid),
        .ready      (ready),
        .busy       (busy),
        .frame_error(frame_error),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];

    int t_start;
    int busy_rise  = -1;
    int busy_fall  = -1;
    int valid_rise = -1;
    int vlen       = 0;
    int fe_cnt     = 0;
    int ov_cnt     = 0;
    int ov_cyc     = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // caller is always aligned 1ns after a rising edge
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gbit);
        rx = 1'b0;
        t_start = cyc;
        hold(16);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            if (k == gbit) begin
                hold(8);
                rx = ~b[k];
                hold(1);
                rx = b[k];
                hold(7);
            end else begin
                hold(16);
            end
        end
        rx = stop_bit;
        hold(16);
        rx = 1'b1;
    endtask

    // monitor: pops the scoreboard on every accepted byte
    initial begin
        logic       busy_q;
        logic       valid_q;
        logic       ready_q;
        logic [7:0] held;
        logic [7:0] e;
        busy_q  = 1'b0;
        valid_q = 1'b0;
        ready_q = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_q  = 1'b0;
                valid_q = 1'b0;
            end else begin
                if (busy && !busy_q) busy_rise = cyc;
                if (!busy && busy_q) busy_fall = cyc;
                if (valid && !valid_q) begin
                    valid_rise = cyc;
                    vlen = 0;
                end
                if (valid) vlen++;
                if (frame_error) fe_cnt++;
                if (overrun) begin
                    ov_cnt++;
                    ov_cyc = cyc;
                end
                if (frame_error || overrun)
                    chk("fe_ov_exclusive", {31'd0, frame_error & overrun}, 32'd0);
                if (valid_q && !ready_q) begin
                    chk("hold_valid", {31'd0, valid}, 32'd1);
                    chk("hold_data", {24'd0, data_out}, {24'd0, held});
                end
                if (valid && ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_byte: got %0h expected none", data_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rx_byte", {24'd0, data_out}, {24'd0, e});
                    end
                end
                busy_q  = busy;
                valid_q = valid;
                ready_q = ready;
                held    = data_out;
            end
        end
    end

    initial begin
        int fe0;
        int g0;
        int r0;
        int t1;
        rx    = 1'b1;
        ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_fe", {31'd0, frame_error}, 32'd0);
        chk("rst_ov", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        hold(5);

        // 0xA5 with ready held high
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1, -1);
        hold(5);
        chk("a5_busy_rise", busy_rise, t_start + 3);
        chk("a5_busy_fall", busy_fall, t_start + 155);
        chk("a5_valid_rise", valid_rise, t_start + 155);
        chk("a5_valid_len", vlen, 1);
        chk("a5_drained", exp_q.size(), 0);
        chk("a5_no_fe", fe_cnt, 0);
        chk("a5_no_ov", ov_cnt, 0);

        // back-to-back with consumer stalled: second byte overruns
        ready = 1'b0;
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1, -1);
        send_byte(8'hC3, 1'b1, -1);
        t1 = t_start;
        hold(5);
        chk("b2b_ov_cnt", ov_cnt, 1);
        chk("b2b_ov_cyc", ov_cyc, t1 + 155);
        chk("b2b_valid", {31'd0, valid}, 32'd1);
        chk("b2b_data", {24'd0, data_out}, 32'h3C);
        ready = 1'b1;
        hold(3);
        chk("b2b_valid_drop", {31'd0, valid}, 32'd0);
        chk("b2b_drained", exp_q.size(), 0);

        // stop bit low, then a clean frame
        fe0 = fe_cnt;
        send_byte(8'h55, 1'b0, -1);
        hold(10);
        chk("fe_pulse", fe_cnt, fe0 + 1);
        chk("fe_no_valid", {31'd0, valid}, 32'd0);
        exp_q.push_back(8'h12);
        send_byte(8'h12, 1'b1, -1);
        hold(5);
        chk("after_fe_drained", exp_q.size(), 0);

        // 5-cycle glitch rejected at half-bit check
        fe0 = fe_cnt;
        rx = 1'b0;
        g0 = cyc;
        hold(5);
        rx = 1'b1;
        hold(30);
        chk("gl_busy_rise", busy_rise, g0 + 3);
        chk("gl_busy_fall", busy_fall, g0 + 11);
        chk("gl_no_fe", fe_cnt, fe0);
        chk("gl_no_valid", {31'd0, valid}, 32'd0);

        // break: line low for three frame times
        rx = 1'b0;
        hold(480);
        chk("brk_busy", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        r0 = cyc;
        hold(10);
        chk("brk_fe_once", fe_cnt, fe0 + 1);
        chk("brk_busy_fall", busy_fall, r0 + 3);
        chk("brk_no_valid", {31'd0, valid}, 32'd0);
        chk("brk_drained", exp_q.size(), 0);

        // async reset mid-DATA of 0xF0
        rx = 1'b0;
        hold(16);
        for (int k = 0; k < 4; k++) begin
            rx = (k >= 4);
            hold(16);
        end
        chk("mid_busy", {31'd0, busy}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_data", {24'd0, data_out}, 32'd0);
        chk("arst_valid", {31'd0, valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_fe", {31'd0, frame_error}, 32'd0);
        chk("arst_ov", {31'd0, overrun}, 32'd0);
        rx = 1'b1;
        hold(3);
        rst_n = 1'b1;
        hold(5);
        exp_q.push_back(8'h0F);
        send_byte(8'h0F, 1'b1, -1);
        hold(5);
        chk("post_rst_data", {24'd0, data_out}, 32'h0F);
        chk("post_rst_drained", exp_q.size(), 0);

`ifdef UART_RX_MAJORITY_EN
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1, 3);
        hold(5);
        chk("maj_drained", exp_q.size(), 0);
`endif

        chk("final_queue", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
